scoreboard_hazard_unit: RTL and testbench
=========================================

Name: scoreboard_hazard_unit

Overview:
- Parametrised successor to the five-stage hazard/bypass control logic.
- Tracks in-flight loads of variable latency in a per-register scoreboard plus an in-order load-destination FIFO, so decode stalls only on real dependencies.
- Generalises bypass selection to NUM_BYPASS forwarding stages and counts stall cycles.
- Sits between the decode stage and the existing stall unit, replacing the fixed execute/memory/writeback comparisons.

Parameters:
- CORE, 0, core index printed in scan output.
- REG_BITS, 5, register-index width; NUM_REGS = 2**REG_BITS.
- NUM_BYPASS, 3, number of forwarding stages; index 1 is youngest (execute).
- LOAD_DEPTH, 4, maximum outstanding loads; must be at least 1.
- SCAN_CYCLES_MIN, 0, first cycle of scan display.
- SCAN_CYCLES_MAX, 1000, last cycle of scan display.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; 0 resets the block.
- issue_valid  in  1  decode holds a valid instruction.
- issue_rs1, issue_rs2  in  REG_BITS each  source indices.
- issue_rs1_read, issue_rs2_read  in  1 each  source is actually read.
- issue_rd  in  REG_BITS  destination index.
- issue_regWrite  in  1  instruction writes rd.
- issue_is_load  in  1  instruction is a load.
- issue_ready  out  1  decode may advance this cycle.
- stage_rd  in  NUM_BYPASS*REG_BITS  rd of stage k in slice k-1.
- stage_regWrite  in  NUM_BYPASS  stage k writes its rd.
- stage_fwd_valid  in  NUM_BYPASS  stage k result is available for forwarding.
- load_return_valid  in  1  oldest outstanding load has written back.
- rs1_bypass_sel, rs2_bypass_sel  out  SEL_BITS = clog2(NUM_BYPASS+1)  0 selects the register file, k selects stage k.
- load_count  out  clog2(LOAD_DEPTH+1)  current number of outstanding loads.
- stall_cycles  out  32  saturating count of stall cycles.
- scan  in  1  enables debug display.

Behaviour:
- Reset values: FIFO empty; every pending count 0; load_count 0; stall_cycles 0. Outputs then follow combinationally: issue_ready is 1 and both bypass selects are 0.
- Source match: source s matches stage k when s is read, s != 0, stage_regWrite[k] is 1 and stage_rd[k] equals s.
- Bypass select: the lowest-numbered matching stage wins. With no match the select is 0. Selects are combinational, with zero latency.
- Source hazard: the source is pending in the scoreboard (count != 0), or the winning match stage has stage_fwd_valid = 0.
- Structural hazard: issue_is_load while the FIFO is full and load_return_valid is 0.
- issue_ready = !(valid & (rs1 hazard | rs2 hazard | structural hazard)).
- Issue fires when issue_valid & issue_ready & issue_is_load & issue_regWrite & issue_rd != 0. On fire: push issue_rd into the FIFO and increment pending[issue_rd].
  - Loads to x0 are not tracked but still occupy a FIFO entry, so return order stays aligned. Their pending increment is suppressed.
- Return: on load_return_valid, pop the FIFO head and decrement pending[head].
  - load_return_valid while the FIFO is empty is ignored.
  - Under `ifdef SIM`, an empty-FIFO return prints an error.
- Push and pop in the same cycle: both take effect. If the FIFO was full, the push is allowed. If both target the same register, the pending count is unchanged.
- Scoreboard update visibility: the update lands on the clock edge and decode sees it next cycle. The register file guarantees write-before-read on the return cycle.
- Pending counts are clog2(LOAD_DEPTH+1) bits wide, so they never overflow given FIFO capacity. FIFO pointers wrap modulo LOAD_DEPTH and use an explicit count; LOAD_DEPTH need not be a power of two.
- stall_cycles increments on every cycle with issue_valid & !issue_ready. It saturates at 32'hFFFFFFFF.
- Reset asserted mid-operation clears all state immediately, asynchronously. In-flight loads are forgotten, and the memory system must be flushed alongside.
- Scan: when scan is 1 and the cycle counter is within [SCAN_CYCLES_MIN, SCAN_CYCLES_MAX], display CORE, the cycle, load_count, issue_ready and both selects.

Decomposition:
- Shared package, constants only: the opcode constants (R_TYPE, I_TYPE, STORE, LOAD, BRANCH, JALR, JAL) and the rs1-read/rs2-read decode, reused by the decode wrapper.
- One sub-module: load_dest_fifo. It is parametrised by width REG_BITS and depth LOAD_DEPTH, with push, pop, head, full, empty and count.
- The scoreboard array and bypass priority logic stay in the top module.

Test Plan:
- Reset with no traffic, then an issue reading x5 with no stage matches -> issue_ready=1, both selects 0, load_count=0.
- Stage1 and stage2 both report rd=7 with fwd_valid=1; issue reads rs1=7 -> rs1_bypass_sel=1. Then drop stage1 regWrite -> sel=2.
- Load to x9 issued; next cycle an instruction reads x9 -> issue_ready=0 and stall_cycles increments. Assert load_return_valid -> next cycle issue_ready=1.
- Issue 4 loads (LOAD_DEPTH=4) to x1..x4 -> load_count=4. A 5th load stalls. The 5th issued with load_return_valid=1 in the same cycle -> accepted, load_count stays 4, x1 cleared, x5 set.
- Two loads to x3 in flight, then one return -> reader of x3 still stalls. After the second return it proceeds.
- Load to x0 plus a reader of x0 -> no stall, FIFO count=1. Also: reset driven low mid-stream with 3 loads pending -> load_count=0 and issue_ready=1 asynchronously.

Source files
------------

// File: rtl/scoreboard_hazard_unit_pkg.sv
// ---------------------------------------------------------------------------
// scoreboard_hazard_unit_pkg
// Shared decode constants for the hazard unit and the decode wrapper.
//   - Base opcode constants (R_TYPE, I_TYPE, STORE, LOAD, BRANCH, JALR, JAL)
//   - op_reads_rs1 / op_reads_rs2: whether an opcode actually reads a source.
// ---------------------------------------------------------------------------
package scoreboard_hazard_unit_pkg;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] JAL    = 7'b1101111;

  // JAL has no register sources; everything else listed reads rs1.
  function automatic logic op_reads_rs1(input logic [6:0] opcode);
    return (opcode == R_TYPE) || (opcode == I_TYPE) || (opcode == STORE) ||
           (opcode == LOAD)   || (opcode == BRANCH) || (opcode == JALR);
  endfunction

  // Only register-register ALU ops, stores and branches read rs2.
  function automatic logic op_reads_rs2(input logic [6:0] opcode);
    return (opcode == R_TYPE) || (opcode == STORE) || (opcode == BRANCH);
  endfunction

endpackage

// File: rtl/scoreboard_hazard_unit_if.sv
// ---------------------------------------------------------------------------
// scoreboard_hazard_unit_if
// Bundle between decode / pipeline stages and the hazard unit.
//   master : decode + pipeline side (drives issue_*, stage_*, load_return_valid)
//   slave  : hazard unit (drives issue_ready, bypass selects, load_count,
//            stall_cycles)
// ---------------------------------------------------------------------------
interface scoreboard_hazard_unit_if #(
  parameter int REG_BITS   = 5,
  parameter int NUM_BYPASS = 3,
  parameter int LOAD_DEPTH = 4
);
  localparam int SEL_BITS = $clog2(NUM_BYPASS + 1);
  localparam int CNT_BITS = $clog2(LOAD_DEPTH + 1);

  logic                           issue_valid;
  logic [REG_BITS-1:0]            issue_rs1;
  logic [REG_BITS-1:0]            issue_rs2;
  logic                           issue_rs1_read;
  logic                           issue_rs2_read;
  logic [REG_BITS-1:0]            issue_rd;
  logic                           issue_regWrite;
  logic                           issue_is_load;
  logic                           issue_ready;
  logic [NUM_BYPASS*REG_BITS-1:0] stage_rd;
  logic [NUM_BYPASS-1:0]          stage_regWrite;
  logic [NUM_BYPASS-1:0]          stage_fwd_valid;
  logic                           load_return_valid;
  logic [SEL_BITS-1:0]            rs1_bypass_sel;
  logic [SEL_BITS-1:0]            rs2_bypass_sel;
  logic [CNT_BITS-1:0]            load_count;
  logic [31:0]                    stall_cycles;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rs1_read, issue_rs2_read,
           issue_rd, issue_regWrite, issue_is_load,
           stage_rd, stage_regWrite, stage_fwd_valid, load_return_valid,
    input  issue_ready, rs1_bypass_sel, rs2_bypass_sel, load_count, stall_cycles
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rs1_read, issue_rs2_read,
           issue_rd, issue_regWrite, issue_is_load,
           stage_rd, stage_regWrite, stage_fwd_valid, load_return_valid,
    output issue_ready, rs1_bypass_sel, rs2_bypass_sel, load_count, stall_cycles
  );

endinterface

// File: rtl/scoreboard_hazard_unit_load_dest_fifo.sv
// ---------------------------------------------------------------------------
// load_dest_fifo
// In-order FIFO of outstanding load destinations. Any depth >= 1 (pointers
// wrap modulo DEPTH, occupancy is an explicit counter).
//   clock, reset (async, active-low)
//   push, push_data : enqueue (accepted when not full, or when popping too)
//   pop             : dequeue (ignored when empty)
//   head            : oldest entry
//   full, empty, count
// ---------------------------------------------------------------------------
module load_dest_fifo #(
  parameter  int WIDTH    = 5,
  parameter  int DEPTH    = 4,
  localparam int CNT_BITS = $clog2(DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push,
  input  logic [WIDTH-1:0]    push_data,
  input  logic                pop,
  output logic [WIDTH-1:0]    head,
  output logic                full,
  output logic                empty,
  output logic [CNT_BITS-1:0] count
);
  localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_BITS-1:0] count_q;
  logic                do_push, do_pop;

  function automatic logic [PTR_BITS-1:0] wrap_inc(input logic [PTR_BITS-1:0] p);
    return (p == PTR_BITS'(DEPTH - 1)) ? '0 : p + PTR_BITS'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_BITS'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO is legal.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wrap_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= wrap_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + CNT_BITS'(1);
      else if (do_pop && !do_push) count_q <= count_q - CNT_BITS'(1);
    end
  end

  // Storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// ---------------------------------------------------------------------------
// scoreboard_hazard_unit
// Decode-side hazard/bypass control with a per-register load scoreboard.
//   clock, reset (async, active-low), scan (debug display enable, SIM only)
//   bus (slave): issue_* from decode, stage_* from the NUM_BYPASS forwarding
//   stages, load_return_valid; drives issue_ready, rs1/rs2_bypass_sel,
//   load_count and the saturating stall_cycles counter.
// ---------------------------------------------------------------------------
module scoreboard_hazard_unit
  import scoreboard_hazard_unit_pkg::*;
#(
  parameter int CORE            = 0,
  parameter int REG_BITS        = 5,
  parameter int NUM_BYPASS      = 3,
  parameter int LOAD_DEPTH      = 4,
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000
) (
  input logic                      clock,
  input logic                      reset,
  input logic                      scan,
  scoreboard_hazard_unit_if.slave  bus
);
  localparam int NUM_REGS = 2 ** REG_BITS;
  localparam int SEL_BITS = $clog2(NUM_BYPASS + 1);
  localparam int CNT_BITS = $clog2(LOAD_DEPTH + 1);

  logic [CNT_BITS-1:0] pending_q [NUM_REGS];
  logic [31:0]         stall_q;

  logic                fifo_full, fifo_empty, fifo_pop;
  logic [REG_BITS-1:0] fifo_head, push_rd;
  logic [CNT_BITS-1:0] fifo_count;
  logic                issue_fire, track_push, struct_hazard, ready;
  logic [SEL_BITS:0]   res1, res2;

  // Returns {blocked, sel}: the youngest (lowest-numbered) matching stage
  // wins; blocked means that winner has not produced its result yet.
  function automatic logic [SEL_BITS:0] resolve(
    input logic                           rd_en,
    input logic [REG_BITS-1:0]            src,
    input logic [NUM_BYPASS*REG_BITS-1:0] st_rd,
    input logic [NUM_BYPASS-1:0]          st_wr,
    input logic [NUM_BYPASS-1:0]          st_fwd
  );
    logic [SEL_BITS-1:0] sel;
    logic                blocked;
    sel     = '0;
    blocked = 1'b0;
    for (int k = NUM_BYPASS; k >= 1; k--) begin
      if (rd_en && src != '0 && st_wr[k-1] && st_rd[(k-1)*REG_BITS +: REG_BITS] == src) begin
        sel     = SEL_BITS'(k);
        blocked = ~st_fwd[k-1];
      end
    end
    return {blocked, sel};
  endfunction

  assign res1 = resolve(bus.issue_rs1_read, bus.issue_rs1, bus.stage_rd,
                        bus.stage_regWrite, bus.stage_fwd_valid);
  assign res2 = resolve(bus.issue_rs2_read, bus.issue_rs2, bus.stage_rd,
                        bus.stage_regWrite, bus.stage_fwd_valid);

  assign struct_hazard = bus.issue_is_load & fifo_full & ~bus.load_return_valid;

  assign ready = ~(bus.issue_valid &
                   ((bus.issue_rs1_read && pending_q[bus.issue_rs1] != '0) || res1[SEL_BITS] ||
                    (bus.issue_rs2_read && pending_q[bus.issue_rs2] != '0) || res2[SEL_BITS] ||
                    struct_hazard));

  // Every issued load takes a FIFO slot so returns stay aligned; only loads
  // with a real destination are tracked, the rest are stored as x0.
  assign issue_fire = bus.issue_valid & ready & bus.issue_is_load;
  assign track_push = issue_fire & bus.issue_regWrite & (bus.issue_rd != '0);
  assign push_rd    = track_push ? bus.issue_rd : '0;
  assign fifo_pop   = bus.load_return_valid & ~fifo_empty;

  load_dest_fifo #(
    .WIDTH (REG_BITS),
    .DEPTH (LOAD_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (issue_fire),
    .push_data (push_rd),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pend
    logic                inc, dec;
    logic [CNT_BITS-1:0] pending_d;
    assign inc = track_push && (bus.issue_rd == REG_BITS'(gi));
    assign dec = fifo_pop && (gi != 0) && (fifo_head == REG_BITS'(gi));
    // Push and pop to the same register cancel out.
    assign pending_d = (inc && !dec) ? pending_q[gi] + CNT_BITS'(1) :
                       (dec && !inc) ? pending_q[gi] - CNT_BITS'(1) : pending_q[gi];
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) pending_q[gi] <= '0;
      else        pending_q[gi] <= pending_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                   stall_q <= '0;
    else if (bus.issue_valid && !ready && stall_q != '1) stall_q <= stall_q + 32'd1;
  end

  assign bus.issue_ready    = ready;
  assign bus.rs1_bypass_sel = res1[SEL_BITS-1:0];
  assign bus.rs2_bypass_sel = res2[SEL_BITS-1:0];
  assign bus.load_count     = fifo_count;
  assign bus.stall_cycles   = stall_q;

`ifdef SIM
  logic [31:0] cycle_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cycle_q <= '0;
    else        cycle_q <= cycle_q + 32'd1;
  end

  always @(posedge clock) begin
    if (reset && bus.load_return_valid && fifo_empty)
      $display("ERROR core %0d: load return with no outstanding load", CORE);
    if (reset && scan && cycle_q >= 32'(SCAN_CYCLES_MIN) && cycle_q <= 32'(SCAN_CYCLES_MAX))
      $display("core %0d cycle %0d load_count=%0d issue_ready=%0d rs1_sel=%0d rs2_sel=%0d",
               CORE, cycle_q, fifo_count, ready, res1[SEL_BITS-1:0], res2[SEL_BITS-1:0]);
  end
`else
  logic [31:0] unused_scan_cfg;
  assign unused_scan_cfg = {31'b0, scan} ^ 32'(CORE) ^ 32'(SCAN_CYCLES_MIN) ^ 32'(SCAN_CYCLES_MAX);
`endif

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
module tb_scoreboard_hazard_unit;
  localparam int RB = 5;
  localparam int NB = 3;
  localparam int LD = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic scan  = 1'b0;

  always #5 clk = ~clk;

  scoreboard_hazard_unit_if #(.REG_BITS(RB), .NUM_BYPASS(NB), .LOAD_DEPTH(LD)) bus ();

  scoreboard_hazard_unit #(
    .CORE(0), .REG_BITS(RB), .NUM_BYPASS(NB), .LOAD_DEPTH(LD),
    .SCAN_CYCLES_MIN(0), .SCAN_CYCLES_MAX(1000)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .scan  (scan),
    .bus   (bus)
  );

  typedef struct {
    string tag;
    int    ready;
    int    sel1;
    int    sel2;
    int    lcnt;
    int    stall;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   exp_stall = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input string tag, input int rdy, input int s1, input int s2, input int lc);
    exp_t e;
    e.tag = tag; e.ready = rdy; e.sel1 = s1; e.sel2 = s2; e.lcnt = lc; e.stall = exp_stall;
    exp_q.push_back(e);
  endtask

  task automatic compare_head();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: no expectation queued, got nothing to compare");
      return;
    end
    e = exp_q.pop_front();
    $display("[%0t] %s ready=%0d sel=%0d/%0d load_count=%0d stall=%0d", $time, e.tag,
             bus.issue_ready, bus.rs1_bypass_sel, bus.rs2_bypass_sel, bus.load_count, bus.stall_cycles);
    check_val({e.tag, ".ready"}, 32'(bus.issue_ready),    e.ready);
    check_val({e.tag, ".sel1"},  32'(bus.rs1_bypass_sel), e.sel1);
    check_val({e.tag, ".sel2"},  32'(bus.rs2_bypass_sel), e.sel2);
    check_val({e.tag, ".lcnt"},  32'(bus.load_count),     e.lcnt);
    check_val({e.tag, ".stall"}, bus.stall_cycles,        e.stall);
  endtask

  // One transaction: queue expectation, sample at negedge, advance past the edge.
  task automatic cycle(input string tag, input int rdy, input int s1, input int s2, input int lc);
    push_exp(tag, rdy, s1, s2, lc);
    @(negedge clk);
    compare_head();
    if (bus.issue_valid && rdy == 0 && rst_n) exp_stall++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 0; bus.issue_rs1 = '0; bus.issue_rs2 = '0;
    bus.issue_rs1_read = 0; bus.issue_rs2_read = 0; bus.issue_rd = '0;
    bus.issue_regWrite = 0; bus.issue_is_load = 0;
    bus.stage_rd = '0; bus.stage_regWrite = '0; bus.stage_fwd_valid = '0;
    bus.load_return_valid = 0;
  endtask

  task automatic set_issue(input logic v, input int rs1, input logic r1, input int rs2,
                           input logic r2, input int rd, input logic wr, input logic ld);
    bus.issue_valid = v; bus.issue_rs1 = RB'(rs1); bus.issue_rs1_read = r1;
    bus.issue_rs2 = RB'(rs2); bus.issue_rs2_read = r2; bus.issue_rd = RB'(rd);
    bus.issue_regWrite = wr; bus.issue_is_load = ld;
  endtask

  task automatic set_stage(input int k, input int rd, input logic wr, input logic fwd);
    bus.stage_rd[(k-1)*RB +: RB] = RB'(rd);
    bus.stage_regWrite[k-1]      = wr;
    bus.stage_fwd_valid[k-1]     = fwd;
  endtask

  initial begin
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    cycle("reset", 1, 0, 0, 0);
    rst_n = 1;

    // Plain reader, no forwarding stage matches.
    set_issue(1, 5, 1, 5, 1, 0, 0, 0);
    cycle("no_match", 1, 0, 0, 0);

    // Bypass priority; rd=x0 in stage 3 must never match.
    set_stage(1, 7, 1, 1); set_stage(2, 7, 1, 1); set_stage(3, 0, 1, 1);
    set_issue(1, 7, 1, 0, 1, 0, 0, 0);
    cycle("fwd_s1", 1, 1, 0, 0);
    set_stage(1, 7, 0, 1);
    set_issue(1, 7, 1, 7, 1, 0, 0, 0);
    cycle("fwd_s2", 1, 2, 2, 0);
    set_stage(2, 7, 1, 0);
    cycle("fwd_not_ready", 0, 2, 2, 0);
    set_stage(1, 7, 1, 1); set_stage(2, 7, 1, 1);
    set_issue(1, 7, 0, 7, 1, 0, 0, 0);
    cycle("fwd_rs2_only", 1, 0, 1, 0);
    idle();

    // Load-use stall and release after the return.
    set_issue(1, 0, 0, 0, 0, 9, 1, 1);
    cycle("load_x9", 1, 0, 0, 0);
    set_issue(1, 9, 1, 0, 0, 0, 0, 0);
    cycle("raw_x9", 0, 0, 0, 1);
    bus.load_return_valid = 1;
    cycle("raw_x9_ret", 0, 0, 0, 1);
    bus.load_return_valid = 0;
    cycle("raw_x9_clear", 1, 0, 0, 0);

    // Fill the FIFO, then push into a full FIFO alongside a return.
    for (int i = 1; i <= 4; i++) begin
      set_issue(1, 0, 0, 0, 0, i, 1, 1);
      cycle($sformatf("load_x%0d", i), 1, 0, 0, i - 1);
    end
    set_issue(1, 0, 0, 0, 0, 5, 1, 1);
    cycle("load_full", 0, 0, 0, 4);
    bus.load_return_valid = 1;
    cycle("load_full_ret", 1, 0, 0, 4);
    bus.load_return_valid = 0;
    set_issue(1, 1, 1, 0, 0, 0, 0, 0);
    cycle("x1_cleared", 1, 0, 0, 4);
    set_issue(1, 5, 1, 0, 0, 0, 0, 0);
    cycle("x5_set", 0, 0, 0, 4);
    idle();
    bus.load_return_valid = 1;
    for (int i = 4; i >= 1; i--) cycle($sformatf("drain_%0d", i), 1, 0, 0, i);
    bus.load_return_valid = 0;
    cycle("drained", 1, 0, 0, 0);

    // Two loads to the same register need two returns.
    set_issue(1, 0, 0, 0, 0, 3, 1, 1);
    cycle("ld3_a", 1, 0, 0, 0);
    cycle("ld3_b", 1, 0, 0, 1);
    idle();
    bus.load_return_valid = 1;
    cycle("ret3_a", 1, 0, 0, 2);
    bus.load_return_valid = 0;
    set_issue(1, 0, 0, 3, 1, 0, 0, 0);
    cycle("x3_still", 0, 0, 0, 1);
    bus.load_return_valid = 1;
    cycle("x3_ret_b", 0, 0, 0, 1);
    bus.load_return_valid = 0;
    cycle("x3_free", 1, 0, 0, 0);

    // Load to x0 occupies a slot but never blocks readers of x0.
    set_issue(1, 0, 1, 0, 1, 0, 1, 1);
    cycle("ld_x0", 1, 0, 0, 0);
    set_issue(1, 0, 1, 0, 1, 0, 0, 0);
    cycle("rd_x0", 1, 0, 0, 1);
    idle();
    bus.load_return_valid = 1;
    cycle("ret_x0", 1, 0, 0, 1);
    bus.load_return_valid = 0;
    cycle("x0_done", 1, 0, 0, 0);

    // Asynchronous reset with three loads outstanding.
    for (int i = 0; i < 3; i++) begin
      set_issue(1, 0, 0, 0, 0, 10 + i, 1, 1);
      cycle($sformatf("ld_x%0d", 10 + i), 1, 0, 0, i);
    end
    set_issue(1, 10, 1, 0, 0, 0, 0, 0);
    cycle("pre_rst", 0, 0, 0, 3);
    #2;
    rst_n = 0;
    exp_stall = 0;
    #1;
    push_exp("async_rst", 1, 0, 0, 0);
    compare_head();
    cycle("rst_hold", 1, 0, 0, 0);
    rst_n = 1;
    cycle("post_rst", 1, 0, 0, 0);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
